// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants and the E pipe-register control bundle
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] S_AOK = 4'h8;
  localparam logic [3:0] S_HLT = 4'h4;
  localparam logic [3:0] S_ADR = 4'h2;
  localparam logic [3:0] S_INS = 4'h1;

  // Data words are parametric in width, so they live beside this bundle rather than in it.
  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } e_reg_t;

  function automatic e_reg_t e_bubble_ctrl(input logic [3:0] stat);
    e_reg_t b;
    b.stat  = stat;
    b.icode = I_NOP;
    b.ifun  = 4'h0;
    b.src_a = RNONE;
    b.src_b = RNONE;
    b.dst_e = RNONE;
    b.dst_m = RNONE;
    return b;
  endfunction

  function automatic logic idx_valid(input logic [3:0] idx, input int nregs);
    return (idx != RNONE) && (int'(idx) < nregs);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - Y86-64 register file: two async read ports, dual write with M-over-E priority
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int NREGS       = 15,
  parameter int RF_INIT_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              rd_a_idx_i,
  input  logic [3:0]              rd_b_idx_i,
  output logic [DATA_W-1:0]       rd_a_data_o,
  output logic [DATA_W-1:0]       rd_b_data_o,
  input  logic [3:0]              wr_e_idx_i,
  input  logic [DATA_W-1:0]       wr_e_data_i,
  input  logic [3:0]              wr_m_idx_i,
  input  logic [DATA_W-1:0]       wr_m_data_i,
  output logic [NREGS*DATA_W-1:0] dump_o
);

  logic [DATA_W-1:0]       regs_q [NREGS];
  logic [DATA_W-1:0]       regs_d [NREGS];
  logic [NREGS*DATA_W-1:0] dump_q;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (RF_INIT_IDX == 1) ? DATA_W'(i) : '0;
  endfunction

  // The M write is applied after the E write so it wins on a shared index.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_valid(wr_e_idx_i, NREGS) && wr_e_idx_i == 4'(i)) regs_d[i] = wr_e_data_i;
      if (idx_valid(wr_m_idx_i, NREGS) && wr_m_idx_i == 4'(i)) regs_d[i] = wr_m_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i]                   <= init_val(i);
        dump_q[i*DATA_W +: DATA_W]  <= init_val(i);
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i]                   <= regs_d[i];
        dump_q[i*DATA_W +: DATA_W]  <= regs_q[i];
      end
    end
  end

  always_comb begin
    rd_a_data_o = '0;
    rd_b_data_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_a_idx_i != RNONE && rd_a_idx_i == 4'(i)) rd_a_data_o = regs_q[i];
      if (rd_b_idx_i != RNONE && rd_b_idx_i == 4'(i)) rd_b_data_o = regs_q[i];
    end
  end

  assign dump_o = dump_q;

endmodule

// File: rtl/y86_decode_stage_p.sv
// rtl/y86_decode_stage_p.sv - Y86-64 decode stage: source/dest select, forwarding, D->E register
module y86_decode_stage_p
  import y86_pkg::*;
#(
  parameter int         DATA_W      = 64,
  parameter int         NREGS       = 15,
  parameter int         RSP_IDX     = 4,
  parameter int         RF_INIT_IDX = 0,
  parameter logic [3:0] BUBBLE_STAT = 4'h8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              D_stat,
  input  logic [3:0]              D_icode,
  input  logic [3:0]              D_ifun,
  input  logic [3:0]              D_rA,
  input  logic [3:0]              D_rB,
  input  logic [DATA_W-1:0]       D_valC,
  input  logic [DATA_W-1:0]       D_valP,
  input  logic [3:0]              e_dstE,
  input  logic [DATA_W-1:0]       e_valE,
  input  logic [3:0]              M_dstE,
  input  logic [3:0]              M_dstM,
  input  logic [DATA_W-1:0]       M_valE,
  input  logic [DATA_W-1:0]       m_valM,
  input  logic [3:0]              W_dstE,
  input  logic [3:0]              W_dstM,
  input  logic [DATA_W-1:0]       W_valE,
  input  logic [DATA_W-1:0]       W_valM,
  input  logic                    E_stall,
  input  logic                    E_bubble,
  output logic [3:0]              E_stat,
  output logic [3:0]              E_icode,
  output logic [3:0]              E_ifun,
  output logic [3:0]              E_srcA,
  output logic [3:0]              E_srcB,
  output logic [3:0]              E_dstE,
  output logic [3:0]              E_dstM,
  output logic [DATA_W-1:0]       E_valA,
  output logic [DATA_W-1:0]       E_valB,
  output logic [DATA_W-1:0]       E_valC,
  output logic [3:0]              d_srcA,
  output logic [3:0]              d_srcB,
  output logic                    d_load_use,
  output logic [NREGS*DATA_W-1:0] reg_dump
);

  localparam logic [3:0] RSP = 4'(RSP_IDX);

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rval_a, rval_b, val_a, val_b;

  e_reg_t            e_ctrl_q, e_ctrl_d;
  logic [DATA_W-1:0] e_vala_q, e_vala_d;
  logic [DATA_W-1:0] e_valb_q, e_valb_d;
  logic [DATA_W-1:0] e_valc_q, e_valc_d;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      I_RRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
      I_IRMOVQ: dst_e = D_rB;
      I_RMMOVQ: begin src_a = D_rA; src_b = D_rB; end
      I_MRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
      I_OPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
      I_CALL:   begin src_b = RSP;  dst_e = RSP; end
      I_RET:    begin src_a = RSP;  src_b = RSP; dst_e = RSP; end
      I_PUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP;  src_b = RSP; dst_e = RSP; dst_m = D_rA; end
      default:  ;
    endcase
  end

  y86_regfile #(
    .DATA_W      (DATA_W),
    .NREGS       (NREGS),
    .RF_INIT_IDX (RF_INIT_IDX)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_a_idx_i  (src_a),
    .rd_b_idx_i  (src_b),
    .rd_a_data_o (rval_a),
    .rd_b_data_o (rval_b),
    .wr_e_idx_i  (W_dstE),
    .wr_e_data_i (W_valE),
    .wr_m_idx_i  (W_dstM),
    .wr_m_data_i (W_valM),
    .dump_o      (reg_dump)
  );

  // Newest producer wins; W_dstM sits above W_dstE to match the write priority.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [3:0] src, input logic [DATA_W-1:0] rval);
    if (src == RNONE)       return rval;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rval;
  endfunction

  always_comb begin
    if (D_icode == I_CALL || D_icode == I_JXX) val_a = D_valP;
    else                                       val_a = fwd_sel(src_a, rval_a);
    val_b = fwd_sel(src_b, rval_b);
  end

  always_comb begin
    e_ctrl_d = e_ctrl_q;
    e_vala_d = e_vala_q;
    e_valb_d = e_valb_q;
    e_valc_d = e_valc_q;
    if (E_bubble) begin
      e_ctrl_d = e_bubble_ctrl(BUBBLE_STAT);
      e_vala_d = '0;
      e_valb_d = '0;
      e_valc_d = '0;
    end else if (!E_stall) begin
      e_ctrl_d.stat  = D_stat;
      e_ctrl_d.icode = D_icode;
      e_ctrl_d.ifun  = D_ifun;
      e_ctrl_d.src_a = src_a;
      e_ctrl_d.src_b = src_b;
      e_ctrl_d.dst_e = dst_e;
      e_ctrl_d.dst_m = dst_m;
      e_vala_d       = val_a;
      e_valb_d       = val_b;
      e_valc_d       = D_valC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ctrl_q <= e_bubble_ctrl(BUBBLE_STAT);
      e_vala_q <= '0;
      e_valb_q <= '0;
      e_valc_q <= '0;
    end else begin
      e_ctrl_q <= e_ctrl_d;
      e_vala_q <= e_vala_d;
      e_valb_q <= e_valb_d;
      e_valc_q <= e_valc_d;
    end
  end

  assign E_stat  = e_ctrl_q.stat;
  assign E_icode = e_ctrl_q.icode;
  assign E_ifun  = e_ctrl_q.ifun;
  assign E_srcA  = e_ctrl_q.src_a;
  assign E_srcB  = e_ctrl_q.src_b;
  assign E_dstE  = e_ctrl_q.dst_e;
  assign E_dstM  = e_ctrl_q.dst_m;
  assign E_valA  = e_vala_q;
  assign E_valB  = e_valb_q;
  assign E_valC  = e_valc_q;

  assign d_srcA = src_a;
  assign d_srcB = src_b;

  // Reported only; stalling on it is the pipeline controller's job.
  assign d_load_use = (e_ctrl_q.icode == I_MRMOVQ || e_ctrl_q.icode == I_POPQ) &&
                      (e_ctrl_q.dst_m != RNONE) &&
                      (e_ctrl_q.dst_m == src_a || e_ctrl_q.dst_m == src_b);

endmodule

// File: tb/tb_y86_decode_stage_p.sv
// tb/tb_y86_decode_stage_p.sv - scoreboard bench for y86_decode_stage_p
module tb_y86_decode_stage_p;

  localparam int DW = 64;
  localparam int NR = 15;

  typedef logic [219:0]   evec_t;
  typedef logic [NR*DW-1:0] dump_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [DW-1:0] D_valC, D_valP;
  logic [3:0]    e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic          E_stall, E_bubble;
  logic [3:0]    E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [DW-1:0] E_valA, E_valB, E_valC;
  logic [3:0]    d_srcA, d_srcB;
  logic          d_load_use;
  dump_t         reg_dump;

  always #5 clk = ~clk;

  y86_decode_stage_p #(
    .DATA_W(DW), .NREGS(NR), .RSP_IDX(4), .RF_INIT_IDX(1), .BUBBLE_STAT(4'h8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_load_use(d_load_use), .reg_dump(reg_dump)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mregs [NR];
  evec_t         m_e;
  evec_t         e_q [$];
  dump_t         d_q [$];
  logic [8:0]    c_q [$];

  function automatic evec_t bubble_vec();
    evec_t v;
    v = '0;
    v[219:192] = {4'h8, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    return v;
  endfunction

  function automatic dump_t init_dump();
    dump_t d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = DW'(i);
    return d;
  endfunction

  function automatic evec_t dut_e();
    return {E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM, E_valA, E_valB, E_valC};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = DW'(i);
    m_e = bubble_vec();
  endtask

  function automatic logic [DW-1:0] rd(input logic [3:0] idx);
    if (idx == 4'hF || int'(idx) >= NR) return '0;
    return mregs[idx];
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [3:0] src);
    if (src == 4'hF)   return '0;
    if (src == e_dstE) return e_valE;
    if (src == M_dstM) return m_valM;
    if (src == M_dstE) return M_valE;
    if (src == W_dstM) return W_valM;
    if (src == W_dstE) return W_valE;
    return rd(src);
  endfunction

  task automatic compare_dump(input string name, input dump_t act, input dump_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int i = 0; i < NR; i++)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s slot %0d: got %h expected %h", name, i, act[i*DW +: DW], exp[i*DW +: DW]);
          break;
        end
    end
  endtask

  task automatic compare_e(input string name, input evec_t act, input evec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+2 with D/forward/W/control inputs already set; returns at the next posedge+2.
  task automatic step();
    logic [3:0]    sa, sb, de, dm, eic, edm;
    logic [DW-1:0] va, vb;
    logic          lu;
    dump_t         dp;
    evec_t         nx;
    sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
    case (D_icode)
      4'h2: begin sa = D_rA; de = D_rB; end
      4'h3: de = D_rB;
      4'h4: begin sa = D_rA; sb = D_rB; end
      4'h5: begin sb = D_rB; dm = D_rA; end
      4'h6: begin sa = D_rA; sb = D_rB; de = D_rB; end
      4'h8: begin sb = 4'h4; de = 4'h4; end
      4'h9: begin sa = 4'h4; sb = 4'h4; de = 4'h4; end
      4'hA: begin sa = D_rA; sb = 4'h4; de = 4'h4; end
      4'hB: begin sa = 4'h4; sb = 4'h4; de = 4'h4; dm = D_rA; end
      default: ;
    endcase
    va  = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : fwd(sa);
    vb  = fwd(sb);
    eic = m_e[215:212];
    edm = m_e[195:192];
    lu  = (eic == 4'h5 || eic == 4'hB) && edm != 4'hF && (edm == sa || edm == sb);
    c_q.push_back({sa, sb, lu});
    for (int i = 0; i < NR; i++) dp[i*DW +: DW] = mregs[i];
    d_q.push_back(dp);
    if (E_bubble)     nx = bubble_vec();
    else if (E_stall) nx = m_e;
    else              nx = {D_stat, D_icode, D_ifun, sa, sb, de, dm, va, vb, D_valC};
    e_q.push_back(nx);
    m_e = nx;
    if (W_dstE != 4'hF && int'(W_dstE) < NR) mregs[W_dstE] = W_valE;
    if (W_dstM != 4'hF && int'(W_dstM) < NR) mregs[W_dstM] = W_valM;
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    E_stall = 1'b0; E_bubble = 1'b0;
  endtask

  function automatic logic [3:0] pick_dst();
    return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
  endfunction

  task automatic rand_inputs();
    D_stat  = 4'($urandom_range(0, 15));
    D_icode = 4'($urandom_range(0, 15));
    D_ifun  = 4'($urandom_range(0, 15));
    D_rA    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    D_rB    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    D_valC  = {$urandom, $urandom};
    D_valP  = {$urandom, $urandom};
    e_dstE  = pick_dst(); M_dstE = pick_dst(); M_dstM = pick_dst();
    W_dstE  = pick_dst(); W_dstM = pick_dst();
    e_valE  = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
    m_valM  = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
    W_valM  = {$urandom, $urandom};
    E_stall  = ($urandom_range(0, 3) == 0);
    E_bubble = ($urandom_range(0, 7) == 0);
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
    D_icode = icode; D_rA = ra; D_rB = rb;
    D_stat  = 4'($urandom_range(0, 15));
    D_ifun  = 4'($urandom_range(0, 15));
    D_valC  = {$urandom, $urandom};
    D_valP  = {$urandom, $urandom};
  endtask

  // Monitor: E/dump checked just after each edge, combinational outputs late in the cycle.
  initial begin
    evec_t      ee;
    dump_t      ed;
    logic [8:0] ce;
    forever begin
      @(posedge clk);
      #1;
      if (e_q.size() > 0) begin
        ee = e_q.pop_front();
        ed = d_q.pop_front();
        compare_e("e_reg", dut_e(), ee);
        compare_dump("reg_dump", reg_dump, ed);
      end
      #6;
      if (c_q.size() > 0) begin
        ce = c_q.pop_front();
        n_cmp++;
        if ({d_srcA, d_srcB, d_load_use} !== ce) begin
          n_bad++;
          $display("FAIL comb srcA/srcB/load_use: got %h/%h/%b expected %h/%h/%b",
                   d_srcA, d_srcB, d_load_use, ce[8:5], ce[4:1], ce[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    quiet();
    set_d(4'h1, 4'hF, 4'hF);
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    model_reset();
    @(posedge clk);
    #1;
    compare_e("reset_e", dut_e(), bubble_vec());
    compare_dump("reset_dump", reg_dump, init_dump());
    #1;
    rst_n = 1'b1;

    set_d(4'h6, 4'h2, 4'h3); step();

    set_d(4'h6, 4'h5, 4'h1);
    e_dstE = 4'h5; e_valE = 64'h11;
    M_dstM = 4'h5; m_valM = 64'h22;
    W_dstE = 4'h5; W_valE = 64'h33;
    step();
    e_dstE = 4'hF; step();
    M_dstM = 4'hF; step();
    quiet();

    W_dstE = 4'h7; W_dstM = 4'h7; W_valE = 64'hA; W_valM = 64'hB;
    set_d(4'h1, 4'hF, 4'hF); step();
    quiet();
    set_d(4'h6, 4'h7, 4'h7); step();
    step();

    set_d(4'h5, 4'h2, 4'h1); step();
    set_d(4'h6, 4'h2, 4'h3); step();
    set_d(4'h5, 4'hF, 4'h1); step();
    set_d(4'h6, 4'h2, 4'h3); step();
    set_d(4'hB, 4'h3, 4'h0); step();
    set_d(4'h2, 4'h3, 4'h1); step();

    set_d(4'h6, 4'h1, 4'h2); step();
    E_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin set_d(4'($urandom_range(2, 11)), 4'h0, 4'h3); step(); end
    E_bubble = 1'b1; step();
    quiet();

    for (int i = 0; i < 150; i++) begin rand_inputs(); step(); end

    quiet();
    set_d(4'h6, 4'h2, 4'h3); step();
    #2;
    rst_n = 1'b0;
    #1;
    compare_e("async_reset_e", dut_e(), bubble_vec());
    compare_dump("async_reset_dump", reg_dump, init_dump());
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) begin rand_inputs(); step(); end
    quiet();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (e_q.size() != 0 || c_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", e_q.size(), c_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
